// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter
//
// Shares a single FPU between NumReq requesters. Requests are arbitrated
// round-robin and tagged with the requester index. Results come back tagged
// and are routed to the requester that issued them. Each requester may have at
// most MaxOutstanding operations in flight.
//
// Handshake semantics (all channels): a transfer happens in a cycle where
// valid and ready are both 1. A source must hold valid and its payload stable
// until the transfer completes. Ready may depend combinationally on valid.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drops all in-flight bookkeeping; forwarded as fpu_flush_o
//   req_valid_i/ready_o  per-requester request channel, payload req_data_i
//   fpu_valid_o/ready_i  request channel to the FPU: fpu_data_o, fpu_tag_o
//   fpu_out_valid_i/
//   fpu_out_ready_o      result channel from the FPU: fpu_result_i,
//                        fpu_status_i, fpu_tag_i
//   rsp_valid_o/ready_i  per-requester response channel. rsp_result_o and
//                        rsp_status_o are shared by all requesters
//   busy_o               an operation is in flight or a request is offered
//   err_o                sticky: a result arrived with no matching outstanding op
module fpu_share_arbiter #(
  parameter int NumReq         = 2,
  parameter int ReqWidth       = 128,
  parameter int WIDTH          = 32,
  parameter int MaxOutstanding = 4,
  localparam int IdWidth       = $clog2(NumReq)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NumReq-1:0]                 req_valid_i,
  output logic [NumReq-1:0]                 req_ready_o,
  input  logic [NumReq-1:0][ReqWidth-1:0]   req_data_i,
  output logic                              fpu_valid_o,
  input  logic                              fpu_ready_i,
  output logic [ReqWidth-1:0]               fpu_data_o,
  output logic [IdWidth-1:0]                fpu_tag_o,
  output logic                              fpu_flush_o,
  input  logic                              fpu_out_valid_i,
  output logic                              fpu_out_ready_o,
  input  logic [WIDTH-1:0]                  fpu_result_i,
  input  logic [4:0]                        fpu_status_i,
  input  logic [IdWidth-1:0]                fpu_tag_i,
  output logic [NumReq-1:0]                 rsp_valid_o,
  input  logic [NumReq-1:0]                 rsp_ready_i,
  output logic [WIDTH-1:0]                  rsp_result_o,
  output logic [4:0]                        rsp_status_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int CntW = 4;
  localparam logic [CntW-1:0] CntLimit = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] CntSat   = '1;

  // Grant lock: once a request is offered to the FPU and stalls, the grant
  // stays on that requester until it is accepted.
  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_state_e;

  lock_state_e             lock_state_q, lock_state_d;
  logic [IdWidth-1:0]      lock_idx_q, lock_idx_d;
  logic [IdWidth-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]         cnt_q [NumReq];
  logic                    err_q;

  logic [NumReq-1:0]       eligible;
  logic                    any_grant;
  logic [IdWidth-1:0]      win;
  logic                    fpu_hs;
  logic [NumReq-1:0]       cnt_inc;
  logic [NumReq-1:0]       cnt_dec;
  logic                    tag_known;
  logic [CntW-1:0]         tag_cnt;
  logic                    tag_rsp_ready;
  logic                    stray;
  logic                    err_set;
  logic                    any_cnt;

  // ---------------------------------------------------------------------------
  // Request arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < CntLimit) && !flush_i;
    end

    win       = ptr_q;
    any_grant = 1'b0;
    if (lock_state_q == LOCK_HELD) begin
      // A locked requester that drops valid leaves the FPU idle for one
      // cycle; the lock then falls away because nothing is offered.
      win       = lock_idx_q;
      any_grant = eligible[lock_idx_q];
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        if (!any_grant && eligible[(int'(ptr_q) + k) % NumReq]) begin
          any_grant = 1'b1;
          win       = IdWidth'((int'(ptr_q) + k) % NumReq);
        end
      end
    end

    fpu_hs      = any_grant && fpu_ready_i;
    req_ready_o = '0;
    if (any_grant) begin
      req_ready_o[win] = fpu_ready_i;
    end
  end

  assign fpu_valid_o = any_grant;
  assign fpu_tag_o   = win;
  assign fpu_data_o  = req_data_i[win];
  assign fpu_flush_o = flush_i;

  // Lock FSM and round-robin pointer next state. Flush forces any_grant low,
  // so it also clears the lock.
  always_comb begin
    lock_state_d = LOCK_IDLE;
    lock_idx_d   = lock_idx_q;
    if (any_grant && !fpu_ready_i) begin
      lock_state_d = LOCK_HELD;
      lock_idx_d   = win;
    end

    ptr_d = ptr_q;
    if (fpu_hs) begin
      ptr_d = IdWidth'((int'(win) + 1) % NumReq);
    end
  end

  // ---------------------------------------------------------------------------
  // Result routing
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_known     = 1'b0;
    tag_cnt       = '0;
    tag_rsp_ready = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (fpu_tag_i == IdWidth'(i)) begin
        tag_known     = 1'b1;
        tag_cnt       = cnt_q[i];
        tag_rsp_ready = rsp_ready_i[i];
      end
    end

    // A result nobody is waiting for is swallowed and flagged.
    stray = !tag_known || (tag_cnt == '0);

    rsp_valid_o = '0;
    if (fpu_out_valid_i && !flush_i && !stray) begin
      for (int i = 0; i < NumReq; i++) begin
        if (fpu_tag_i == IdWidth'(i)) rsp_valid_o[i] = 1'b1;
      end
    end

    if (flush_i)    fpu_out_ready_o = 1'b1;
    else if (stray) fpu_out_ready_o = fpu_out_valid_i;
    else            fpu_out_ready_o = tag_rsp_ready;

    err_set = fpu_out_valid_i && !flush_i && stray;
  end

  assign rsp_result_o = fpu_result_i;
  assign rsp_status_o = fpu_status_i;

  always_comb begin
    any_cnt = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cnt_inc[i] = fpu_hs && (win == IdWidth'(i));
      cnt_dec[i] = rsp_valid_o[i] && rsp_ready_i[i];
      if (cnt_q[i] != '0) any_cnt = 1'b1;
    end
  end

  assign busy_o = any_cnt || any_grant;
  assign err_o  = err_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_state_q <= LOCK_IDLE;
      lock_idx_q   <= '0;
      ptr_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
      ptr_q        <= ptr_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Outstanding counters: simultaneous issue and retire cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (flush_i) begin
          cnt_q[i] <= '0;
        end else if (cnt_inc[i] && !cnt_dec[i]) begin
          if (cnt_q[i] != CntSat) cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (cnt_dec[i] && !cnt_inc[i]) begin
          if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Shares one FPU instance (valid/ready request side, tagged result side) between NumReq independent requesters, e.g. the integer core issue stage and an offload/accelerator port.
- Arbitrates requests round-robin and stamps each request with the requester index as the FPU tag.
- Routes each tagged result back to its originating requester.
- Enforces a per-requester outstanding-operation limit and handles flush.

Parameters:
- NumReq, 2, number of requesters (≥2).
- ReqWidth, 128, width of the opaque request payload (operands, op, formats, rounding mode) forwarded to the FPU.
- WIDTH, 32, FPU result width.
- MaxOutstanding, 4, maximum in-flight operations per requester (1..15).
- IdWidth, $clog2(NumReq), localparam, tag width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous flush of all in-flight state; also forwarded to the FPU.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester request accepted.
- req_data_i  in  NumReq×ReqWidth  per-requester payload.
- fpu_valid_o  out  1  request valid to FPU.
- fpu_ready_i  in  1  FPU input ready.
- fpu_data_o  out  ReqWidth  granted payload.
- fpu_tag_o  out  IdWidth  granted requester index.
- fpu_flush_o  out  1  equals flush_i.
- fpu_out_valid_i  in  1  FPU result valid.
- fpu_out_ready_o  out  1  result accepted.
- fpu_result_i  in  WIDTH  FPU result.
- fpu_status_i  in  5  FPU status flags (NV,DZ,OF,UF,NX).
- fpu_tag_i  in  IdWidth  result tag.
- rsp_valid_o  out  NumReq  per-requester response valid.
- rsp_ready_i  in  NumReq  per-requester response ready.
- rsp_result_o  out  WIDTH  shared response data.
- rsp_status_o  out  5  shared response status.
- busy_o  out  1  any operation in flight or pending.
- err_o  out  1  sticky: result arrived for a requester with zero outstanding.

Behaviour:
- Reset values: all outputs 0; round-robin pointer = 0; outstanding counters = 0; lock clear; err_o = 0.
- Eligibility: requester i is eligible when req_valid_i[i]=1 and cnt[i] < MaxOutstanding. A requester at its limit is masked from arbitration.
- Arbitration (combinational, zero latency): pick the first eligible requester starting at the pointer, wrapping modulo NumReq.
  - fpu_valid_o = any eligible.
  - fpu_data_o and fpu_tag_o reflect the winner.
  - req_ready_o[winner] = fpu_ready_i; all other req_ready_o = 0.
- Pointer update: on an accepted handshake (fpu_valid_o & fpu_ready_i), pointer ← winner+1 mod NumReq. No update otherwise.
- Stability (lock): if fpu_valid_o=1 and fpu_ready_i=0, register lock=1 and the locked index. While locked, the grant stays on the locked requester regardless of other valids. Lock clears on handshake or flush.
  - Requesters must hold valid/data until ready. If a locked requester drops valid (protocol violation), the lock releases next cycle.
- Counters, per requester, saturating width 4 bits:
  - +1 on accepted FPU handshake for that index.
  - −1 on response handshake (rsp_valid_o[i] & rsp_ready_i[i]).
  - Simultaneous +1/−1 on the same counter: value unchanged.
- Response routing (combinational, zero latency):
  - rsp_valid_o[fpu_tag_i] = fpu_out_valid_i; other bits 0.
  - fpu_out_ready_o = rsp_ready_i[fpu_tag_i].
  - rsp_result_o and rsp_status_o pass through fpu_result_i and fpu_status_i.
- Stray result: if a result arrives with cnt[tag]=0, set err_o=1 (sticky until reset), still accept it (fpu_out_ready_o=1), and suppress rsp_valid_o.
- Out-of-range tag (≥NumReq): same as stray result.
- Flush: in the flush cycle, no request is accepted (req_ready_o=0, fpu_valid_o=0) and no response is presented (rsp_valid_o=0, fpu_out_ready_o=1). Next cycle, all counters = 0, lock cleared, pointer unchanged.
- busy_o = |cnt | fpu_valid_o.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). FPU contents are discarded by the FPU's own reset.

Test Plan:
- Two requesters both valid, fpu_ready_i=1 for 4 cycles → fpu_tag_o sequence 0,1,0,1; cnt=[2,2]; busy_o=1.
- Req0 valid with fpu_ready_i=0 for 3 cycles while req1 becomes valid in cycle 2 → fpu_tag_o stays 0 and fpu_data_o stays stable. Handshake on cycle 4 to req0, then req1 granted next.
- MaxOutstanding=4: req0 issues 4 ops with no results returned → fifth request blocked (req_ready_o[0]=0), while req1 is still granted in the same cycle.
- Result tag=1, rsp_ready_i[1]=0 for 2 cycles then 1 → fpu_out_ready_o=0,0,1; cnt[1] decrements only on the third cycle. A same-cycle new grant to req1 leaves cnt[1] unchanged.
- flush_i pulse with cnt=[3,1] and a locked pending request → that cycle has no handshake; next cycle cnt=[0,0], lock clear, busy_o=0 if no valids.
- Result with tag=0 while cnt[0]=0 → err_o=1 permanently, rsp_valid_o=0, fpu_out_ready_o=1; reset clears err_o.
